// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator, unsigned or two's complement.
// Holds registered lt/gt/eq and operand-sign flags until the next operation.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             negselect,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             xneg,
    output logic             yneg
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] xr, yr, xr_n, yr_n;
    logic             negr, negr_n;
    logic [IW-1:0]    idx, idx_n;
    logic             dlt, dgt, dlt_n, dgt_n;
    logic             done_n, lt_n, gt_n, eq_n;
    logic             xneg_n, yneg_n;
    logic             xb, yb, sgn, hit_lt, hit_gt;
    logic             decided, hit, last;

    assign busy = (state == RUN);

    // Sign bits compare in the opposite sense when signed.
    assign xb      = xr[idx];
    assign yb      = yr[idx];
    assign sgn     = negr && (idx == TOP);
    assign hit_gt  = sgn ? (!xb && yb) : (xb && !yb);
    assign hit_lt  = sgn ? (xb && !yb) : (!xb && yb);
    assign decided = dlt || dgt;
    assign hit     = !decided && (hit_lt || hit_gt);
    assign last    = (idx == '0);

    always_comb begin
        state_n = state;
        xr_n    = xr;
        yr_n    = yr;
        negr_n  = negr;
        idx_n   = idx;
        dlt_n   = dlt;
        dgt_n   = dgt;
        done_n  = 1'b0;
        lt_n    = lt;
        gt_n    = gt;
        eq_n    = eq;
        xneg_n  = xneg;
        yneg_n  = yneg;
        unique case (state)
            IDLE: begin
                if (start) begin
                    xr_n    = x;
                    yr_n    = y;
                    negr_n  = negselect;
                    xneg_n  = negselect && x[WIDTH-1];
                    yneg_n  = negselect && y[WIDTH-1];
                    idx_n   = TOP;
                    dlt_n   = 1'b0;
                    dgt_n   = 1'b0;
                    lt_n    = 1'b0;
                    gt_n    = 1'b0;
                    eq_n    = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (hit) begin
                    dlt_n = hit_lt;
                    dgt_n = hit_gt;
                end
                if ((EARLY_EXIT && hit) || last) begin
                    lt_n    = dlt_n;
                    gt_n    = dgt_n;
                    eq_n    = !(dlt_n || dgt_n);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            negr  <= 1'b0;
            idx   <= TOP;
            dlt   <= 1'b0;
            dgt   <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            xneg  <= 1'b0;
            yneg  <= 1'b0;
        end else begin
            state <= state_n;
            xr    <= xr_n;
            yr    <= yr_n;
            negr  <= negr_n;
            idx   <= idx_n;
            dlt   <= dlt_n;
            dgt   <= dgt_n;
            done  <= done_n;
            lt    <= lt_n;
            gt    <= gt_n;
            eq    <= eq_n;
            xneg  <= xneg_n;
            yneg  <= yneg_n;
        end
    end

endmodule
